writeback_unit: RTL and testbench
=================================

# writeback_unit

Drives the register file's single write port (rf_we / rf_rd_addr / rf_din) from two result sources.
- ALU results are single-cycle and have fixed priority.
- Long-latency results (load/multiply unit) arrive over a valid/ready handshake and are buffered in a small FIFO until the write port is free.
- An optional scoreboard tracks destinations of in-flight long-latency operations so the issue stage can stall on RAW/WAW hazards.

## Interface
Parameters:
- DEPTH, 4: long-path FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global stall enable; low freezes all state
- alu_valid  in  1  ALU result valid this cycle; no backpressure
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  long-path result valid
- mem_ready  out  1  long-path result accepted when mem_valid && mem_ready
- mem_rd  in  5  long-path destination register
- mem_data  in  32  long-path result
- issue_valid  in  1  long-latency op issued this cycle (scoreboard set)
- issue_rd  in  5  destination of issued op
- rf_we  out  1  register file write enable (registered)
- rf_rd_addr  out  5  register file write address (registered)
- rf_din  out  32  register file write data (registered)
- pending  out  32  per-register in-flight flag (scoreboard)
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- All state updates only on rising clk with clk_en=1. With clk_en=0, state and outputs hold and mem_ready=0.
- Write selection each enabled cycle, in priority order:
  - alu_valid && alu_rd≠0: ALU result wins.
  - else FIFO non-empty: FIFO head is popped.
  - else idle.
- The selected write is loaded into the rf_* registers. Otherwise rf_we←0 and rf_rd_addr/rf_din hold.
- Writes to x0 never assert rf_we. The ALU result is discarded. A FIFO head with rd=0 is popped and discarded, and that pop consumes the write slot.
- mem_ready = clk_en && (fifo_count < DEPTH). There is no same-cycle push-on-full even if a pop occurs.
- On accept, {mem_rd, mem_data} is pushed at the tail. Order is preserved and there is no bypass: an entry pushed at edge N is popped no earlier than edge N+1.
- Simultaneous push and pop leaves the count unchanged. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Scoreboard:
  - issue_valid && issue_rd≠0 sets pending[issue_rd].
  - A long-path write committed to rf_* (FIFO pop with rd≠0) clears pending[rd].
  - Set and clear of the same bit in the same cycle: set wins.
  - ALU writes never clear pending.
  - pending[0] is constant 0.

## Timing
- Reset (async assert, sync release): rf_we=0, rf_rd_addr=0, rf_din=0, FIFO empty, fifo_count=0, pending=0. mem_ready=clk_en after reset.
- ALU latency: alu_valid at cycle N gives rf_we=1 in cycle N+1.
- Long-path latency when uncontended: accepted at edge N gives rf_we=1 in cycle N+2.
- A continuous ALU stream starves the FIFO. Sustained back-to-back ALU writes keep mem_ready low once the FIFO is full; this is the intended backpressure.
- Reset asserted mid-operation discards FIFO contents and pending bits immediately. rf_we drops asynchronously.
- fifo_count and pending are registered and reflect state after the last enabled edge.

## Configuration
- WB_SCOREBOARD_EN defined:
  - pending is driven as above.
  - issue_valid/issue_rd are sampled.
- Not defined:
  - no scoreboard registers are synthesized.
  - pending is tied to 32'h0.
  - issue_valid/issue_rd are ignored.
  - all other behaviour is identical.

## Test plan
- Reset then single ALU write: alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF at cycle 1 -> rf_we=1, rf_rd_addr=5, rf_din=32'hDEADBEEF in cycle 2, rf_we=0 in cycle 3.
- x0 suppression: alu_rd=0, and a mem push with mem_rd=0 -> rf_we never asserts, fifo_count returns to 0.
- Contention/order: push mem results r1=1, r2=2, r3=3 while alu_valid is held high for 6 cycles to r10 -> rf_* shows six r10 writes, then r1, r2, r3 on consecutive cycles, in order.
- Full FIFO with DEPTH=4: hold alu_valid=1 and push 5 mem results -> mem_ready=0 after 4 accepted, fifo_count=4. Release ALU -> drains 4 writes, mem_ready returns high after the first pop.
- clk_en stall: clk_en=0 for 3 cycles mid-drain -> rf_*, fifo_count and pending frozen, mem_ready=0. Resume drains identically.
- Scoreboard (WB_SCOREBOARD_EN): issue_rd=7 -> pending[7]=1. The ALU write to r7 leaves it set. The mem write to r7 committing alongside a new issue_rd=7 keeps it set. The next mem write to r7 clears it. Without the macro, pending stays 0.

Source files
------------

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register file write-port arbiter: ALU priority, buffered long-path results, optional scoreboard (WB_SCOREBOARD_EN)
module writeback_unit #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clk_en,
   input  logic                     alu_valid,
   input  logic [4:0]               alu_rd,
   input  logic [31:0]              alu_data,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [4:0]               mem_rd,
   input  logic [31:0]              mem_data,
   input  logic                     issue_valid,
   input  logic [4:0]               issue_rd,
   output logic                     rf_we,
   output logic [4:0]               rf_rd_addr,
   output logic [31:0]              rf_din,
   output logic [31:0]              pending,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [4:0]    fifo_rd   [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic          alu_sel;
   logic          push;
   logic          pop;
   logic [4:0]    head_rd;
   logic [31:0]   head_data;

   // ALU to x0 is not a write, so it does not claim the port
   assign alu_sel   = alu_valid && (alu_rd != 5'd0);
   // full check uses the pre-edge count: no push-on-full even while popping
   assign mem_ready = clk_en && (count < FULL_COUNT);
   assign push      = mem_valid && mem_ready;
   // pop only sees entries already stored, so a push is never bypassed
   assign pop       = clk_en && !alu_sel && (count != '0);
   assign head_rd   = fifo_rd[rd_ptr];
   assign head_data = fifo_data[rd_ptr];
   assign fifo_count = count;

   // FIFO storage; contents are don't-care while not counted
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= mem_rd;
         fifo_data[wr_ptr] <= mem_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Registered write port; address/data hold when nothing is written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we      <= 1'b0;
         rf_rd_addr <= '0;
         rf_din     <= '0;
      end else if (clk_en) begin
         if (alu_sel) begin
            rf_we      <= 1'b1;
            rf_rd_addr <= alu_rd;
            rf_din     <= alu_data;
         end else if (pop && (head_rd != 5'd0)) begin
            rf_we      <= 1'b1;
            rf_rd_addr <= head_rd;
            rf_din     <= head_data;
         end else begin
            rf_we      <= 1'b0;
         end
      end
   end

`ifdef WB_SCOREBOARD_EN
   logic [31:0] pend_q;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   // issue sets, committed long-path write clears; set applied last so it wins
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_valid && (issue_rd != 5'd0)) set_mask[issue_rd] = 1'b1;
      if (pop && (head_rd != 5'd0))          clr_mask[head_rd]  = 1'b1;
   end

   // Scoreboard state; bit 0 forced to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else if (clk_en) begin
         pend_q <= ((pend_q & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
      end
   end

   assign pending = pend_q;
`else
   logic unused_issue;
   assign unused_issue = ^{issue_valid, issue_rd};
   assign pending      = 32'h0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk_en = 1'b1;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [4:0]  mem_rd = '0;
   logic [31:0] mem_data = '0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic        rf_we;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_din;
   logic [31:0] pending;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   writeback_unit #(.DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_din(rf_din),
      .pending(pending), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      issue_valid = 1'b0; issue_rd = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      step();
      step();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", rf_we); end
      checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", rf_rd_addr); end
      checks++; if (rf_din !== 32'h0) begin errors++; $display("FAIL reset_din got %h exp 0", rf_din); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
      checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", pending); end
      rst_n = 1'b1;
      step();
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", mem_ready); end
   endtask

   task automatic test_alu_single();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      step();
      alu_valid = 1'b0;
      checks++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'd5 || rf_din !== 32'hDEADBEEF) begin
         errors++; $display("FAIL alu_write got we=%0b rd=%0d din=%h exp 1/5/deadbeef", rf_we, rf_rd_addr, rf_din);
      end
      step();
      checks++; if (rf_we !== 1'b0 || rf_rd_addr !== 5'd5) begin
         errors++; $display("FAIL alu_release got we=%0b rd=%0d exp 0/5", rf_we, rf_rd_addr);
      end
   endtask

   task automatic test_x0();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1111_1111;
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h2222_2222;
      step();
      idle_inputs();
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd1) begin
         errors++; $display("FAIL x0_push got we=%0b cnt=%0d exp 0/1", rf_we, fifo_count);
      end
      step();
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0 || rf_rd_addr !== 5'd5) begin
         errors++; $display("FAIL x0_pop got we=%0b cnt=%0d rd=%0d exp 0/0/5", rf_we, fifo_count, rf_rd_addr);
      end
   endtask

   task automatic test_contention();
      for (int i = 0; i < 6; i++) begin
         alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA000 + i;
         mem_valid = (i < 3); mem_rd = 5'(i + 1); mem_data = 32'h100 + i + 1;
         step();
         checks++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'd10 || rf_din !== 32'hA000 + i) begin
            errors++; $display("FAIL contend_alu%0d got we=%0b rd=%0d din=%h", i, rf_we, rf_rd_addr, rf_din);
         end
      end
      idle_inputs();
      checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL contend_count got %0d exp 3", fifo_count); end
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'(i) || rf_din !== 32'h100 + i) begin
            errors++; $display("FAIL contend_mem%0d got we=%0b rd=%0d din=%h", i, rf_we, rf_rd_addr, rf_din);
         end
      end
      step();
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin
         errors++; $display("FAIL contend_done got we=%0b cnt=%0d exp 0/0", rf_we, fifo_count);
      end
   endtask

   task automatic test_full_and_stall();
      alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hBBBB;
      for (int k = 0; k < 4; k++) begin
         mem_valid = 1'b1; mem_rd = 5'(20 + k); mem_data = 32'(k);
         checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d got %0b exp 1", k, mem_ready); end
         step();
      end
      mem_rd = 5'd24; mem_data = 32'd4;
      checks++; if (mem_ready !== 1'b0 || fifo_count !== 3'd4) begin
         errors++; $display("FAIL full_state got rdy=%0b cnt=%0d exp 0/4", mem_ready, fifo_count);
      end
      step();
      checks++; if (mem_ready !== 1'b0 || fifo_count !== 3'd4) begin
         errors++; $display("FAIL full_hold got rdy=%0b cnt=%0d exp 0/4", mem_ready, fifo_count);
      end
      idle_inputs();
      step();
      checks++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'd20 || rf_din !== 32'd0 || fifo_count !== 3'd3 || mem_ready !== 1'b1) begin
         errors++; $display("FAIL drain0 got we=%0b rd=%0d din=%h cnt=%0d rdy=%0b", rf_we, rf_rd_addr, rf_din, fifo_count, mem_ready);
      end
      clk_en = 1'b0;
      for (int s = 0; s < 3; s++) begin
         step();
         checks++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'd20 || fifo_count !== 3'd3 || mem_ready !== 1'b0 || pending !== 32'h0) begin
            errors++; $display("FAIL stall%0d got we=%0b rd=%0d cnt=%0d rdy=%0b", s, rf_we, rf_rd_addr, fifo_count, mem_ready);
         end
      end
      clk_en = 1'b1;
      for (int k = 1; k < 4; k++) begin
         step();
         checks++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'(20 + k) || rf_din !== 32'(k) || fifo_count !== 3'(3 - k)) begin
            errors++; $display("FAIL drain%0d got we=%0b rd=%0d din=%h cnt=%0d", k, rf_we, rf_rd_addr, rf_din, fifo_count);
         end
      end
      step();
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin
         errors++; $display("FAIL drain_end got we=%0b cnt=%0d exp 0/0", rf_we, fifo_count);
      end
   endtask

   task automatic test_scoreboard();
      logic [31:0] exp7;
`ifdef WB_SCOREBOARD_EN
      exp7 = 32'h0000_0080;
`else
      exp7 = 32'h0;
`endif
      issue_valid = 1'b1; issue_rd = 5'd7;
      step();
      idle_inputs();
      checks++; if (pending !== exp7) begin errors++; $display("FAIL sb_set got %h exp %h", pending, exp7); end
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      step();
      idle_inputs();
      checks++; if (pending !== exp7) begin errors++; $display("FAIL sb_alu got %h exp %h", pending, exp7); end
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h701;
      step();
      idle_inputs();
      issue_valid = 1'b1; issue_rd = 5'd7;
      step();
      idle_inputs();
      checks++; if (pending !== exp7 || rf_we !== 1'b1 || rf_rd_addr !== 5'd7 || rf_din !== 32'h701) begin
         errors++; $display("FAIL sb_setwins got pend=%h we=%0b rd=%0d din=%h exp %h", pending, rf_we, rf_rd_addr, rf_din, exp7);
      end
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h702;
      step();
      idle_inputs();
      step();
      checks++; if (pending !== 32'h0 || rf_we !== 1'b1 || rf_din !== 32'h702) begin
         errors++; $display("FAIL sb_clear got pend=%h we=%0b din=%h exp 0/1/702", pending, rf_we, rf_din);
      end
   endtask

   task automatic test_reset_mid();
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
      step();
      mem_rd = 5'd4; mem_data = 32'h44;
      step();
      idle_inputs();
      checks++; if (rf_we !== 1'b1 || fifo_count !== 3'd1) begin
         errors++; $display("FAIL midrst_pre got we=%0b cnt=%0d exp 1/1", rf_we, fifo_count);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0 || rf_din !== 32'h0) begin
         errors++; $display("FAIL midrst got we=%0b cnt=%0d din=%h exp 0/0/0", rf_we, fifo_count, rf_din);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0 || mem_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_after got we=%0b cnt=%0d rdy=%0b", rf_we, fifo_count, mem_ready);
      end
   endtask

   initial begin
      test_reset();
      test_alu_single();
      test_x0();
      test_contention();
      test_full_and_stall();
      test_scoreboard();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
